// File: rtl/hazard_md_ctrl.sv
// Hazard controller and multi-cycle MULT/DIV sequencer with HI/LO registers for the 5-stage core.
// Optional feature: define STALL_COUNT_EN to add the free-running stall_cnt output.
module hazard_md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ID_Instr_o,
    input  logic [31:0] EX_Instr_o,
    input  logic [31:0] MEM_Instr_o,
    input  logic [31:0] EX_RD1_o_forward,
    input  logic [31:0] EX_RD2_o_forward,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] HI_o,
    output logic [31:0] LO_o
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_ORI = 6'h0d;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_LUI = 6'h0f;
    localparam logic [5:0] OP_JAL = 6'h03;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    function automatic logic is_r(input logic [31:0] ins, input logic [5:0] fn);
        return (ins[31:26] == OP_R) && (ins[5:0] == fn);
    endfunction

    function automatic logic is_op(input logic [31:0] ins, input logic [5:0] op);
        return ins[31:26] == op;
    endfunction

    function automatic logic is_mdop(input logic [31:0] ins);
        return is_r(ins, FN_MULT) || is_r(ins, FN_MULTU) || is_r(ins, FN_DIV) || is_r(ins, FN_DIVU);
    endfunction

    function automatic logic is_md(input logic [31:0] ins);
        return is_mdop(ins) || is_r(ins, FN_MFHI) || is_r(ins, FN_MFLO) ||
               is_r(ins, FN_MTHI) || is_r(ins, FN_MTLO);
    endfunction

    function automatic logic is_branch(input logic [31:0] ins);
        return is_op(ins, OP_BEQ) || is_r(ins, FN_JR);
    endfunction

    // A returned destination of 0 means "writes nothing that can cause a hazard".
    function automatic logic [4:0] dest(input logic [31:0] ins);
        if (is_r(ins, FN_ADDU) || is_r(ins, FN_SUBU) || is_r(ins, FN_MFHI) || is_r(ins, FN_MFLO))
            return ins[15:11];
        else if (is_op(ins, OP_ORI) || is_op(ins, OP_LUI) || is_op(ins, OP_LW))
            return ins[20:16];
        else if (is_op(ins, OP_JAL))
            return 5'd31;
        else
            return 5'd0;
    endfunction

    function automatic logic reads(input logic [31:0] ins, input logic [4:0] r);
        logic use_rs;
        logic use_rt;
        use_rs = is_op(ins, OP_ORI) || is_op(ins, OP_LW) || is_op(ins, OP_SW) ||
                 is_op(ins, OP_BEQ) || is_r(ins, FN_JR) || is_r(ins, FN_ADDU) ||
                 is_r(ins, FN_SUBU) || is_mdop(ins) || is_r(ins, FN_MTHI) || is_r(ins, FN_MTLO);
        use_rt = is_op(ins, OP_SW) || is_op(ins, OP_BEQ) || is_r(ins, FN_ADDU) ||
                 is_r(ins, FN_SUBU) || is_mdop(ins) || is_r(ins, FN_MTHI) || is_r(ins, FN_MTLO);
        return (r != 5'd0) && ((use_rs && ins[25:21] == r) || (use_rt && ins[20:16] == r));
    endfunction

    // op[1] selects divide, op[0] selects signed; a zero divisor keeps HI/LO.
    function automatic logic [63:0] md_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
        logic [31:0] q;
        logic [31:0] r;
        if (!op[1]) begin
            if (op[0])
                return 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
            else
                return {32'd0, a} * {32'd0, b};
        end
        if (b == 32'd0)
            return {hi, lo};
        if (op[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic stall_lw_use;
    logic stall_br_ex;
    logic stall_br_mem;
    logic stall_md;

    assign md_busy = (state_q == S_BUSY);
    assign HI_o    = hi_q;
    assign LO_o    = lo_q;

    always_comb begin
        stall_lw_use = is_op(EX_Instr_o, OP_LW) && reads(ID_Instr_o, EX_Instr_o[20:16]);
        stall_br_ex  = is_branch(ID_Instr_o) && reads(ID_Instr_o, dest(EX_Instr_o));
        stall_br_mem = is_branch(ID_Instr_o) && is_op(MEM_Instr_o, OP_LW) &&
                       reads(ID_Instr_o, MEM_Instr_o[20:16]);
        stall_md     = is_md(ID_Instr_o) && (md_busy || is_mdop(EX_Instr_o));
        stall        = stall_lw_use || stall_br_ex || stall_br_mem || stall_md;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (is_mdop(EX_Instr_o)) begin
                    op_d    = {is_r(EX_Instr_o, FN_DIV) || is_r(EX_Instr_o, FN_DIVU),
                               is_r(EX_Instr_o, FN_MULT) || is_r(EX_Instr_o, FN_DIV)};
                    a_d     = EX_RD1_o_forward;
                    b_d     = EX_RD2_o_forward;
                    cnt_d   = op_d[1] ? DIV_N : MULT_N;
                    state_d = S_BUSY;
                end else if (is_r(EX_Instr_o, FN_MTHI)) begin
                    hi_d = EX_RD1_o_forward;
                end else if (is_r(EX_Instr_o, FN_MTLO)) begin
                    lo_d = EX_RD1_o_forward;
                end
            end
            default: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    {hi_d, lo_d} = md_result(op_q, a_q, b_q, hi_q, lo_q);
                    cnt_d        = 4'd0;
                    state_d      = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand latches are pure data; they are only consulted while BUSY.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= 32'd0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Bench for hazard_md_ctrl: table of stall vectors plus MULT/DIV runs scored through a queue.
// Build with STALL_COUNT_EN defined to also exercise the stall counter.
module tb_hazard_md_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_i, ex_i, mem_i, rd1, rd2;
    logic        stall, md_busy;
    logic [31:0] hi, lo;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    hazard_md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_Instr_o      (id_i),
        .EX_Instr_o      (ex_i),
        .MEM_Instr_o     (mem_i),
        .EX_RD1_o_forward(rd1),
        .EX_RD2_o_forward(rd2),
        .stall           (stall),
        .md_busy         (md_busy),
        .HI_o            (hi),
        .LO_o            (lo)
`ifdef STALL_COUNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       nm;
    } exp_t;
    exp_t sb[$];

    // Drive one MULT/DIV in E for a single cycle (then bubble), count busy and stall
    // cycles while D holds d_ins, and compare HI/LO once the engine goes idle.
    task automatic run_md(input string nm, input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] d_ins, input int exp_busy,
                          input int exp_stall, input logic [31:0] ehi, input logic [31:0] elo);
        int   busy_n;
        int   stall_n;
        exp_t e;
        sb.push_back('{ehi, elo, nm});
        id_i = d_ins; ex_i = ins; rd1 = a; rd2 = b;
        #1;
        stall_n = stall ? 1 : 0;
        busy_n  = 0;
        @(posedge clk); #1;
        ex_i = 32'd0; rd1 = 32'd0; rd2 = 32'd0;
        #1;
        while (md_busy && busy_n < 40) begin
            busy_n++;
            if (stall) stall_n++;
            @(posedge clk); #2;
        end
        chk({nm, " busy_cycles"}, 32'(busy_n), 32'(exp_busy));
        chk({nm, " stall_cycles"}, 32'(stall_n), 32'(exp_stall));
        e = sb.pop_front();
        chk({e.nm, " HI"}, hi, e.hi);
        chk({e.nm, " LO"}, lo, e.lo);
        id_i = 32'd0;
    endtask

    typedef struct {
        logic [31:0] id;
        logic [31:0] ex;
        logic [31:0] mem;
        logic        exp;
        string       nm;
    } vec_t;
    vec_t vt[16];

    initial begin
        vt[0]  = '{r_ins(8, 10, 9, 6'h21), i_ins(6'h23, 29, 8, 0), 32'd0, 1'b1, "lw_use_addu"};
        vt[1]  = '{r_ins(0, 10, 9, 6'h21), i_ins(6'h23, 29, 0, 0), 32'd0, 1'b0, "lw_use_r0"};
        vt[2]  = '{i_ins(6'h04, 8, 0, 0), r_ins(1, 2, 8, 6'h21), 32'd0, 1'b1, "beq_after_addu"};
        vt[3]  = '{i_ins(6'h04, 0, 0, 0), r_ins(1, 2, 0, 6'h21), 32'd0, 1'b0, "beq_after_addu_r0"};
        vt[4]  = '{r_ins(8, 0, 0, 6'h08), 32'd0, i_ins(6'h23, 29, 8, 0), 1'b1, "jr_after_mem_lw"};
        vt[5]  = '{r_ins(0, 0, 0, 6'h08), 32'd0, i_ins(6'h23, 29, 0, 0), 1'b0, "jr_after_mem_lw_r0"};
        vt[6]  = '{i_ins(6'h2b, 9, 8, 4), i_ins(6'h23, 29, 8, 0), 32'd0, 1'b1, "lw_use_sw_rt"};
        vt[7]  = '{i_ins(6'h0f, 0, 8, 16'h1234), i_ins(6'h23, 29, 8, 0), 32'd0, 1'b0, "lw_then_lui"};
        vt[8]  = '{r_ins(8, 10, 9, 6'h21), r_ins(1, 2, 8, 6'h21), 32'd0, 1'b0, "addu_fwd_no_stall"};
        vt[9]  = '{r_ins(8, 10, 9, 6'h21), 32'd0, i_ins(6'h23, 29, 8, 0), 1'b0, "mem_lw_alu_no_stall"};
        vt[10] = '{r_ins(8, 0, 0, 6'h08), i_ins(6'h0d, 1, 8, 5), 32'd0, 1'b1, "jr_after_ori"};
        vt[11] = '{r_ins(31, 0, 0, 6'h08), {6'h03, 26'd100}, 32'd0, 1'b1, "jr_after_jal"};
        vt[12] = '{r_ins(0, 0, 4, 6'h12), r_ins(1, 2, 0, 6'h18), 32'd0, 1'b1, "mflo_after_mult"};
        vt[13] = '{r_ins(0, 0, 4, 6'h12), 32'd0, 32'd0, 1'b0, "mflo_idle"};
        vt[14] = '{i_ins(6'h0d, 8, 9, 1), i_ins(6'h23, 29, 8, 0), 32'd0, 1'b1, "lw_use_ori_rs"};
        vt[15] = '{i_ins(6'h04, 8, 0, 0), i_ins(6'h2b, 9, 8, 0), 32'd0, 1'b0, "beq_after_sw"};

        reset = 1'b1;
        id_i = 32'd0; ex_i = 32'd0; mem_i = 32'd0; rd1 = 32'd0; rd2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset md_busy", {31'd0, md_busy}, 32'd0);
        chk("reset HI", hi, 32'd0);
        chk("reset LO", lo, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;

        // Combinational stall vectors: applied between edges, cleared before the next posedge.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            id_i = vt[i].id; ex_i = vt[i].ex; mem_i = vt[i].mem;
            #1;
            chk({"stall ", vt[i].nm}, {31'd0, stall}, {31'd0, vt[i].exp});
            id_i = 32'd0; ex_i = 32'd0; mem_i = 32'd0;
        end

        @(posedge clk); #1;
        run_md("mult_3xm2", r_ins(1, 2, 0, 6'h18), 32'h3, 32'hFFFF_FFFE, 32'd0, 5, 0,
               32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("divu_7_2_mflo", r_ins(1, 2, 0, 6'h1b), 32'd7, 32'd2, r_ins(0, 0, 4, 6'h12),
               10, 11, 32'd1, 32'd3);
        run_md("div_m7_2", r_ins(1, 2, 0, 6'h1a), 32'hFFFF_FFF9, 32'd2, 32'd0, 10, 0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_by_zero", r_ins(1, 2, 0, 6'h1a), 32'h1234_5678, 32'd0, 32'd0, 10, 0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("multu_max", r_ins(1, 2, 0, 6'h19), 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               r_ins(3, 5, 0, 6'h18), 5, 6, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("div_7_m2", r_ins(1, 2, 0, 6'h1a), 32'd7, 32'hFFFF_FFFE, 32'd0, 10, 0,
               32'd1, 32'hFFFF_FFFD);
        run_md("divu_100_7", r_ins(1, 2, 0, 6'h1b), 32'd100, 32'd7, 32'd0, 10, 0,
               32'd2, 32'd14);

        // Reset in the middle of a multiply abandons it and clears HI/LO at once.
        ex_i = r_ins(1, 2, 0, 6'h18); rd1 = 32'd5; rd2 = 32'd6;
        @(posedge clk); #1;
        ex_i = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre-reset md_busy", {31'd0, md_busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async reset md_busy", {31'd0, md_busy}, 32'd0);
        chk("async reset HI", hi, 32'd0);
        chk("async reset LO", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abandoned md_busy", {31'd0, md_busy}, 32'd0);
        chk("abandoned LO", lo, 32'd0);

        ex_i = r_ins(3, 0, 0, 6'h11); rd1 = 32'h0000_1234;
        #1;
        chk("mthi before edge", hi, 32'd0);
        @(posedge clk); #1;
        chk("mthi HI", hi, 32'h0000_1234);
        ex_i = r_ins(3, 0, 0, 6'h13); rd1 = 32'hCAFE_0001;
        @(posedge clk); #1;
        chk("mtlo LO", lo, 32'hCAFE_0001);
        chk("mtlo keeps HI", hi, 32'h0000_1234);
        ex_i = 32'd0; rd1 = 32'd0;

`ifdef STALL_COUNT_EN
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("stall_cnt after reset", stall_cnt, 32'd0);
        ex_i = i_ins(6'h23, 29, 8, 0); id_i = r_ins(8, 10, 9, 6'h21);
        repeat (4) @(posedge clk);
        #1;
        ex_i = 32'd0; id_i = 32'd0;
        @(posedge clk); #1;
        chk("stall_cnt four stalls", stall_cnt, 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
